alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter_if.sv | 33 +++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two command sources, one consumer and alu_share_arbiter.
interface alu_share_arbiter_if #(
    parameter int DW = 4,
    parameter int SW = 3
);
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req0_b;
    logic [DW-1:0] req1_b;
    logic [SW-1:0] req0_s;
    logic [SW-1:0] req1_s;
    logic          req0_cin;
    logic          req1_cin;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_f;
    logic          rsp_cout;

    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b,
        input  req0_s, req1_s, req0_cin, req1_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_f, rsp_cout
    );

    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b,
        output req0_s, req1_s, req0_cin, req1_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_cout
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between two requesters, one operation in flight at a time.
// Define FIXED_PRIORITY_EN to let port 0 win every tie instead of round-robin.
module alu_share_arbiter #(
    parameter int DW      = 4,
    parameter int SW      = 3,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [SW-1:0]      alu_s,
    output logic               alu_cin,
    input  logic [DW-1:0]      alu_f,
    input  logic               alu_cout,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [2:0]    lat_cnt;
    logic          grant_id;
    logic          winner;
    logic [1:0]    ready;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_valid_r;
    logic          rsp_id_r;
    logic [DW-1:0] rsp_f_r;
    logic          rsp_cout_r;
`ifndef FIXED_PRIORITY_EN
    logic          rr_ptr;
`endif

    always_comb begin
        winner = 1'b0;
`ifdef FIXED_PRIORITY_EN
        winner = ~bus.req_valid[0];
`else
        case (bus.req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = rr_ptr;
            default: winner = 1'b0;
        endcase
`endif
    end

    assign ready = (state == IDLE && !reset)
                 ? {bus.req_valid[1] & winner, bus.req_valid[0] & ~winner}
                 : 2'b00;
    assign req_fire      = |(bus.req_valid & ready);
    assign rsp_fire      = rsp_valid_r & bus.rsp_ready;
    assign busy          = (state != IDLE);
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_f     = rsp_f_r;
    assign bus.rsp_cout  = rsp_cout_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = WAIT;
            WAIT:    if (lat_cnt == 3'd0) state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands stay on the ALU bus after the op completes; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_s       <= '0;
            alu_cin     <= 1'b0;
            grant_id    <= 1'b0;
            lat_cnt     <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_f_r     <= '0;
            rsp_cout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        grant_id <= winner;
                        lat_cnt  <= LAT_INIT;
                        if (winner) begin
                            alu_a   <= bus.req1_a;
                            alu_b   <= bus.req1_b;
                            alu_s   <= bus.req1_s;
                            alu_cin <= bus.req1_cin;
                        end else begin
                            alu_a   <= bus.req0_a;
                            alu_b   <= bus.req0_b;
                            alu_s   <= bus.req0_s;
                            alu_cin <= bus.req0_cin;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        rsp_f_r     <= alu_f;
                        rsp_cout_r  <= alu_cout;
                        rsp_id_r    <= grant_id;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_fire) rsp_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifndef FIXED_PRIORITY_EN
    // The port just served drops to lower priority, even if it was the only requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          rr_ptr <= 1'b0;
        else if (state == RESP && rsp_fire) rr_ptr <= ~grant_id;
    end
`endif
endmodule
